// File: rtl/imem_prog_fetch.sv
// imem_prog_fetch: loadable instruction RAM, swept to NOP after reset,
// served through a registered, stallable fetch port with an error flag.
module imem_prog_fetch #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  parameter bit CLEAR_ON_RST = 1'b1,
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int BSH = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_err,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack,
  output logic              busy
);
  typedef enum logic {CLEAR, RUN} state_e;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << BSH) - 1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d, rd_data, mem_wdata;
  logic valid_q, valid_d, err_q, err_d, ack_q;
  logic run, accept, fetch_err, load_ok, mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0] mem_waddr;
  assign run = state_q == RUN;
  assign busy = state_q == CLEAR;
  assign fetch_ready = run && !load_en && !stall;
  assign accept = fetch_req && fetch_ready;
  // Range check on the full shifted PC so high addresses never alias low words.
  assign word_idx = fetch_addr >> BSH;
  assign fetch_err = (fetch_addr & OFS_MASK) != '0 || word_idx >= ADDR_W'(DEPTH);
  assign rd_data = mem[word_idx[IDX_W-1:0]];
  assign load_ok = {1'b0, load_addr} < (IDX_W + 1)'(DEPTH);
  assign mem_we = !rst && (busy || (load_en && load_ok));
  assign mem_waddr = busy ? clr_idx_q : load_addr;
  assign mem_wdata = busy ? NOP_WORD : load_data;
  always_comb begin
    clr_idx_d = busy ? clr_idx_q + IDX_W'(1) : clr_idx_q;
    state_d = busy && clr_idx_q == IDX_W'(DEPTH - 1) ? RUN : state_q;
  end
  always_comb begin
    valid_d = stall ? valid_q : accept;
    err_d = stall ? err_q : accept && fetch_err;
    instr_d = stall || !accept ? instr_q : fetch_err ? NOP_WORD : rd_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? CLEAR : RUN;
      clr_idx_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ack_q <= run && load_en;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  assign instr = instr_q;
  assign instr_valid = valid_q;
  assign instr_err = err_q;
  assign load_ack = ack_q;
endmodule

// File: tb/tb_imem_prog_fetch.sv
// tb_imem_prog_fetch: directed + random stimulus, per-edge expectations queued
// by a reference model and compared by an independent monitor.
module tb_imem_prog_fetch;
  localparam int DEPTH = 32;
  localparam logic [31:0] NOP = 32'h0;
  typedef struct packed {
    logic [31:0] instr;
    logic valid, err, ack, busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, fetch_req = 1'b0, stall = 1'b0, load_en = 1'b0;
  logic [31:0] fetch_addr = '0, load_data = '0;
  logic [4:0] load_addr = '0;
  logic fetch_ready, instr_valid, instr_err, load_ack, busy;
  logic [31:0] instr;
  int n_chk = 0, n_pass = 0;
  int clr_left = DEPTH;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] e_instr = NOP;
  logic e_valid = 1'b0, e_err = 1'b0;
  exp_t exp_q[$];

  imem_prog_fetch dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .stall(stall), .instr(instr),
    .instr_valid(instr_valid), .instr_err(instr_err), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference model: memory is all-NOP once a sweep finishes; outputs follow the fetch rules.
  always @(posedge clk) begin
    bit run, ack;
    longint unsigned idx;
    run = clr_left == 0;
    ack = 1'b0;
    if (rst) begin
      clr_left = DEPTH;
      e_instr = NOP;
      e_valid = 1'b0;
      e_err = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = NOP;
    end else begin
      ack = run && load_en;
      if (!stall) begin
        e_valid = run && fetch_req && !load_en;
        e_err = 1'b0;
        if (e_valid) begin
          idx = fetch_addr / 4;
          if (fetch_addr % 4 != 0 || idx >= DEPTH) begin
            e_instr = NOP;
            e_err = 1'b1;
          end else e_instr = ref_mem[idx];
        end
      end
      if (run && load_en && load_addr < DEPTH) ref_mem[load_addr] = load_data;
      if (!run) clr_left--;
    end
    exp_q.push_back('{e_instr, e_valid, e_err, ack, clr_left != 0});
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("instr_valid", instr_valid, e.valid);
      chk("instr", instr, e.instr);
      chk("instr_err", instr_err, e.err);
      chk("load_ack", load_ack, e.ack);
      chk("busy", busy, e.busy);
    end
  end

  task automatic cyc(input bit r, input bit rq, input logic [31:0] a, input bit st,
                     input bit le, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    rst = r; fetch_req = rq; fetch_addr = a; stall = st;
    load_en = le; load_addr = la; load_data = ld;
    #1 chk("fetch_ready", fetch_ready, clr_left == 0 && !le && !st && !r ? 1 : (clr_left == 0 && !le && !st));
  endtask

  initial begin
    logic [31:0] a;
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (34) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h91004489);
    cyc(0, 0, 0, 0, 1, 1, 32'h91005089);
    cyc(0, 1, 32'h0, 0, 0, 0, 0);
    cyc(0, 1, 32'h4, 0, 0, 0, 0);
    cyc(0, 1, 32'h2, 0, 0, 0, 0);
    cyc(0, 1, 32'h80, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 32'hC12A2C01);
    cyc(0, 1, 32'h8, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 32'h0, 1, 0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hC, 0, 1, 3, 32'hDEADBEEF);
    cyc(0, 1, 32'hC, 0, 0, 0, 0);
    cyc(0, 1, 32'h4, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (34) cyc(0, 1, 32'h4, 0, 0, 0, 0);
    repeat (500) begin
      case ($urandom_range(0, 9))
        0: a = $urandom;
        1: a = ($urandom_range(0, 31) << 2) | $urandom_range(1, 3);
        2: a = 32'h80 + ($urandom_range(0, 31) << 2);
        default: a = $urandom_range(0, 31) << 2;
      endcase
      cyc(0, $urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_prog_fetch.md
Name: imem_prog_fetch

Overview:
Parametrised, loadable instruction memory for a NoC processing node.
- Replaces the fixed reset-initialised ROM with a synchronous RAM.
- On reset, a state machine clears the memory to NOPs; the program is then written through a load port.
- Instructions are served through a registered, stallable fetch port. Each returned instruction carries a misalignment/out-of-range error flag.

Parameters:
DATA_W, 32, instruction width in bits; must be 8·2^k.
DEPTH, 32, number of instruction words.
ADDR_W, 32, width of the byte-address PC.
IDX_W, clog2(DEPTH), word-index width (derived; not overridden).
BSH, clog2(DATA_W/8), byte-offset bits (derived; 2 for DATA_W=32).
NOP_WORD, 0, value used for clear fill and for error returns.
CLEAR_ON_RST, 1, 1 = run the CLEAR sweep after reset; 0 = go straight to RUN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  byte address (PC)
fetch_ready  out  1  fetch can be accepted this cycle (combinational)
stall  in  1  downstream stall; freezes the fetch output stage
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  instr is new this cycle
instr_err  out  1  returned word is an error NOP
load_en  in  1  program-write strobe
load_addr  in  IDX_W  word index to write
load_data  in  DATA_W  word to write
load_ack  out  1  one-cycle pulse after each load_en cycle handled in RUN
busy  out  1  CLEAR sweep in progress

Behaviour:
- States: CLEAR, RUN.
- rst=1 at an edge sets:
  - state = CLEAR if CLEAR_ON_RST, else RUN;
  - clr_idx = 0;
  - instr = NOP_WORD; instr_valid = 0; instr_err = 0; load_ack = 0.
  - Memory contents are not reset in zero cycles.
  - rst during CLEAR restarts the sweep at index 0. rst during RUN aborts any in-flight fetch (instr_valid = 0 next cycle).
- busy = (state == CLEAR), combinational from state.
- CLEAR state:
  - Each cycle writes mem[clr_idx] = NOP_WORD and increments clr_idx.
  - After the cycle writing index DEPTH-1, moves to RUN. CLEAR lasts exactly DEPTH cycles.
  - load_en is ignored (no write, no load_ack). fetch_ready = 0.
- fetch_ready = (state == RUN) && !load_en && !stall.
- Fetch is accepted when fetch_req && fetch_ready. Latency is 1 cycle: on the next edge:
  - instr_valid = 1.
  - idx = fetch_addr >> BSH, using the full-width compare with no wrap-around.
  - If fetch_addr[BSH-1:0] != 0 or idx >= DEPTH: instr = NOP_WORD, instr_err = 1.
  - Otherwise: instr = mem[idx], instr_err = 0.
- stall=1: instr, instr_valid and instr_err hold their values. No fetch is accepted.
- No accept and stall=0: instr_valid = 0 and instr_err = 0 next cycle; instr holds its last value.
- Load in RUN:
  - load_en=1 writes mem[load_addr] = load_data at the edge; load_ack = 1 on the following cycle.
  - load_addr >= DEPTH (non-power-of-2 DEPTH): write is dropped, but load_ack still pulses.
  - Back-to-back load_en gives one ack per cycle.
- Load has priority over fetch: a fetch_req while load_en=1 is not accepted, and the requester holds it.
- Read-after-write: a fetch of index i accepted in the cycle after a load to i returns the new data.
- The memory is single write port, single read port; fetch and load never share a cycle.

Test Plan:
- Reset/clear:
  - CLEAR_ON_RST=1, DEPTH=32: hold rst 2 cycles, release → busy=1 for exactly 32 cycles, then 0.
  - fetch_req held throughout → first instr_valid 1 cycle after busy falls; instr = 0x00000000, instr_err = 0.
- Load then fetch:
  - load (idx0 = 0x91004489, idx1 = 0x91005089) back-to-back → load_ack pulses 2 consecutive cycles.
  - Fetch addr 0x0, then 0x4 → instr 0x91004489, then 0x91005089, each 1 cycle after accept; instr_err = 0.
- Error returns:
  - Fetch addr 0x2 → instr = NOP_WORD, instr_err = 1.
  - Fetch addr 0x80 with DEPTH=32 → instr = NOP_WORD, instr_err = 1. Check there is no wrap to mem[0].
- Stall: fetch 0x8 returns 0xC12A2C01; assert stall 3 cycles with fetch_req=1 → instr / instr_valid / instr_err frozen for 3 cycles, no new accept. Deassert → next fetch accepted, result 1 cycle later.
- Load/fetch collision:
  - load_en=1 (idx3 = 0xDEADBEEF) with fetch_req=1, addr 0xC → fetch_ready = 0 that cycle.
  - Next cycle: fetch accepted; instr = 0xDEADBEEF.
- Mid-operation reset:
  - Assert rst at cycle 10 of CLEAR → sweep restarts; busy stays 1 for a full 32 cycles after release.
  - Assert rst with instr_valid=1 → instr_valid = 0 and instr = NOP_WORD next cycle.
